// File: rtl/core_pkg.sv
// Shared core definitions: hazard FSM states, NOP encoding and counter width default.
package core_pkg;

    localparam int DEFAULT_STALL_CNT_W = 16;

    // addi x0, x0, 0 -- what the F/D register loads when flushed
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HOLD,
        ST_DWAIT
    } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: PC/F-D/D-E/E-M hold and flush sequencing plus stall/flush counters.
// Build option HAZARD_FORWARDING_EN: M/W forwarding present, only load-use against E stalls.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int STALL_CNT_W = DEFAULT_STALL_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             addr_rs1_d,
    input  logic [4:0]             addr_rs2_d,
    input  logic                   rs1_used_d,
    input  logic                   rs2_used_d,
    input  logic [4:0]             rd_e,
    input  logic                   regwen_e,
    input  logic                   memread_e,
    input  logic [4:0]             rd_m,
    input  logic                   regwen_m,
    input  logic [4:0]             rd_w,
    input  logic                   regwen_w,
    input  logic                   br_taken_e,
    input  logic                   imem_ready,
    input  logic                   dmem_ready,
    output logic                   pc_we,
    output logic                   fd_we,
    output logic                   fd_flush,
    output logic                   de_we,
    output logic                   de_flush,
    output logic                   em_we,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic [STALL_CNT_W-1:0] flush_events
);

    hz_state_t state, state_nxt;
    logic      boot_cnt;
    logic      match_e, match_m, match_w;
    logic      data_hazard;
    logic      stall_inc, flush_inc;

    // x0 is hardwired, so a write to it never creates a dependency
    assign match_e = (rs1_used_d && regwen_e && (rd_e != 5'd0) && (rd_e == addr_rs1_d)) ||
                     (rs2_used_d && regwen_e && (rd_e != 5'd0) && (rd_e == addr_rs2_d));
    assign match_m = (rs1_used_d && regwen_m && (rd_m != 5'd0) && (rd_m == addr_rs1_d)) ||
                     (rs2_used_d && regwen_m && (rd_m != 5'd0) && (rd_m == addr_rs2_d));
    assign match_w = (rs1_used_d && regwen_w && (rd_w != 5'd0) && (rd_w == addr_rs1_d)) ||
                     (rs2_used_d && regwen_w && (rd_w != 5'd0) && (rd_w == addr_rs2_d));

`ifdef HAZARD_FORWARDING_EN
    logic unused_match;
    assign unused_match = match_m | match_w;
    assign data_hazard  = memread_e && match_e;
`else
    // Register file writes at the edge ending W, so W must also be waited out
    logic unused_memread;
    assign unused_memread = memread_e;
    assign data_hazard    = match_e || match_m || match_w;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_BOOT;
            boot_cnt <= 1'b0;
        end else begin
            state    <= state_nxt;
            boot_cnt <= (state == ST_BOOT) ? ~boot_cnt : 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_BOOT) begin
            state_nxt = boot_cnt ? ST_RUN : ST_BOOT;
        end else if (!dmem_ready) begin
            state_nxt = ST_DWAIT;
        end else if (br_taken_e) begin
            state_nxt = ST_RUN;
        end else if (data_hazard) begin
            state_nxt = ST_HOLD;
        end else begin
            state_nxt = ST_RUN;
        end
    end

    // A pending branch squashes the dependent instruction, so it outranks a data hazard
    always_comb begin
        pc_we    = 1'b0;
        fd_we    = 1'b0;
        fd_flush = 1'b0;
        de_we    = 1'b0;
        de_flush = 1'b0;
        em_we    = 1'b0;
        if (reset) begin
            fd_flush = 1'b1;
            de_flush = 1'b1;
        end else if (state == ST_BOOT) begin
            pc_we    = 1'b1;
            fd_flush = 1'b1;
            de_flush = 1'b1;
            em_we    = 1'b1;
        end else if (!dmem_ready) begin
            pc_we    = 1'b0;
        end else if (br_taken_e) begin
            pc_we    = 1'b1;
            fd_flush = 1'b1;
            de_flush = 1'b1;
            em_we    = 1'b1;
        end else if (data_hazard) begin
            de_flush = 1'b1;
            em_we    = 1'b1;
        end else if (!imem_ready) begin
            fd_flush = 1'b1;
            de_we    = 1'b1;
            em_we    = 1'b1;
        end else begin
            pc_we    = 1'b1;
            fd_we    = 1'b1;
            de_we    = 1'b1;
            em_we    = 1'b1;
        end
    end

    assign stall_inc = !reset && (state != ST_BOOT) && !pc_we;
    assign flush_inc = !reset && (state != ST_BOOT) && br_taken_e && dmem_ready;

    sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    sat_counter #(.W(STALL_CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_events)
    );

endmodule
